// File: rtl/uart_tx_periph_if.sv
// Data-bus interface between the M10 core (master) and the UART TX peripheral (slave).
// Single-cycle request strobe, registered acknowledge and read data.
interface uart_tx_periph_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, ack_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, ack_o
  );
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: bus register block, TX FIFO and serializer FSM.
// Registers: 0x0 TXDATA (write-only push), 0x4 STATUS, 0x8 BAUDDIV.
module uart_tx_periph #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_RESET  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  uart_tx_periph_if.slave   bus,
  output logic              tx_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [3:0] ADDR_TXDATA  = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h4;
  localparam logic [3:0] ADDR_BAUDDIV = 4'h8;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [15:0]      bauddiv;
  logic [15:0]      div_lat;
  logic [15:0]      bit_cnt;
  logic [1:0]       state;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;

  logic             fifo_full;
  logic             fifo_empty;
  logic             wr_txdata;
  logic             push;
  logic             pop;
  logic             bit_done;
  logic [15:0]      div_eff;
  logic             unused_wdata;

  assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (count == '0);
  assign bit_done     = (bit_cnt == 16'd0);
  assign div_eff      = (bauddiv == 16'd0) ? 16'd1 : bauddiv;
  assign unused_wdata = ^bus.wdata_i[31:16];

  // A frame starts from IDLE, or straight out of the last stop-bit cycle when more data is queued.
  assign pop       = !fifo_empty && ((state == IDLE) || (state == STOP && bit_done));
  assign wr_txdata = bus.req_i && bus.we_i && (bus.addr_i == ADDR_TXDATA);
  assign push      = wr_txdata && (!fifo_full || pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.ack_o   <= 1'b0;
      bus.rdata_o <= '0;
      overflow    <= 1'b0;
      bauddiv     <= 16'(DIV_RESET);
    end else begin
      bus.ack_o   <= bus.req_i;
      bus.rdata_o <= '0;
      if (bus.req_i && !bus.we_i) begin
        case (bus.addr_i)
          ADDR_STATUS:  bus.rdata_o <= {28'd0, overflow, fifo_empty, fifo_full, (state != IDLE)};
          ADDR_BAUDDIV: bus.rdata_o <= {16'd0, bauddiv};
          default:      bus.rdata_o <= '0;
        endcase
      end
      if (bus.req_i && bus.we_i) begin
        case (bus.addr_i)
          ADDR_STATUS:  overflow <= 1'b0;
          ADDR_BAUDDIV: bauddiv  <= bus.wdata_i[15:0];
          default:      ;
        endcase
      end
      if (wr_txdata && fifo_full && !pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      fifo_mem[wr_ptr] <= bus.wdata_i[7:0];
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      bit_cnt <= '0;
      div_lat <= 16'(DIV_RESET);
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift   <= fifo_mem[rd_ptr];
            div_lat <= div_eff;
            bit_cnt <= div_eff - 16'd1;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            bit_idx <= 3'd0;
            bit_cnt <= div_lat - 16'd1;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= div_lat - 16'd1;
            if (bit_idx == 3'd7)
              state <= STOP;
            else
              bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (pop) begin
              shift   <= fifo_mem[rd_ptr];
              div_lat <= div_eff;
              bit_cnt <= div_eff - 16'd1;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx_o = 1'b1;
    case (state)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shift[bit_idx];
      default: tx_o = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped UART transmitter peripheral for the Matrak M10 RV32I core. It is the responder end of the core's data bus.
- The core writes bytes into a small TX FIFO over the bus. A serializer FSM drains the FIFO onto an 8N1 serial line.
- Sits beside data memory under top; gives test programs a character output path.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; power of two, minimum 2.
- DIV_RESET, 16, reset value of the BAUDDIV register (clock cycles per serial bit).

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- req_i  input  1  bus request strobe; one cycle per access.
- we_i  input  1  1 = write, 0 = read; qualified by req_i.
- addr_i  input  4  byte offset; 0x0 TXDATA, 0x4 STATUS, 0x8 BAUDDIV; other offsets are reserved.
- wdata_i  input  32  write data.
- rdata_o  output  32  read data; valid while ack_o=1.
- ack_o  output  1  access acknowledge.
- tx_o  output  1  serial output; idle high.

Behaviour:
- Reset (asynchronous assert, synchronous release) sets:
  - ack_o=0, rdata_o=0, tx_o=1
  - FIFO empty, overflow flag=0, BAUDDIV=DIV_RESET, FSM in IDLE.
- Reset during a frame aborts it immediately: tx_o returns to 1 and FIFO contents are discarded.
- Bus handshake:
  - req_i is sampled at edge N. ack_o is 1 for exactly the cycle after edge N.
  - Every access is acknowledged, including reserved offsets. No wait states.
  - req_i asserted on consecutive cycles gives one ack per request.
- Reads:
  - rdata_o is registered at edge N and zero outside ack cycles.
  - STATUS read: bit0 busy (FSM not IDLE), bit1 fifo_full, bit2 fifo_empty, bit3 overflow, other bits 0.
  - BAUDDIV read: zero-extended 16-bit value.
  - TXDATA and reserved offsets read 0.
- Writes:
  - TXDATA: pushes wdata_i[7:0] at edge N if the FIFO is not full. If full, the byte is dropped and overflow is set (sticky).
  - STATUS: any value clears overflow.
  - BAUDDIV: loads wdata_i[15:0]. The new value applies from the next frame start; the current frame keeps its latched divisor. A value of 0 is treated as 1.
  - Reserved offsets: ignored.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count 0..FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push and a pop in the same cycle while full is allowed: the push succeeds, count is unchanged, overflow is not set.
- Serializer FSM (states IDLE, START, DATA, STOP):
  - IDLE: tx_o=1. If the FIFO is non-empty at an edge: pop the head into the shift register, latch the divisor, go to START. tx_o=0 after that edge.
  - START: hold for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx_o = shift[index]; hold each bit DIV cycles. After index 7, go to STOP.
  - STOP: tx_o=1 for DIV cycles. Then, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - Frame length is exactly 10*DIV cycles.
  - The bit-period counter is at least 16 bits and counts DIV-1 down to 0.
- Latency: a TXDATA write strobed at edge N into an idle, empty peripheral gives tx_o falling after edge N+1.

Test Plan:
- Reset and idle:
  - Assert rst_ni=0 mid-frame -> tx_o=1 and ack_o=0 in the same cycle, asynchronously.
  - Release, then read STATUS -> rdata_o=0x00000004.
- Single byte: BAUDDIV write 4, then TXDATA write 0x55.
  - tx_o low after edge N+1 for 4 cycles.
  - Then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4.
  - Total 40 cycles; STATUS bit0=1 throughout, 0 afterwards.
- Back-to-back: DIV=2, write 0xA5 and 0x3C in consecutive cycles.
  - Two frames of 20 cycles each, no idle gap.
  - Decoded bytes are 0xA5 then 0x3C.
- Overflow: DIV=16, FIFO_DEPTH=4, write 6 bytes in consecutive cycles.
  - The first byte is popped, 4 are queued, the 6th is dropped.
  - STATUS = 0xB with full.
  - STATUS write clears bit3.
  - Exactly 5 frames are observed.
- Divisor change mid-frame: during a DIV=4 frame, write BAUDDIV=8 -> current frame stays 40 cycles; the next frame is 80 cycles.
- Bus corner cases:
  - Read offset 0xC -> ack_o after 1 cycle, rdata_o=0.
  - BAUDDIV write 0 -> frame of 10 cycles.
  - req_i held high 3 cycles -> 3 ack pulses.
